sq_operand_engine: RTL and testbench
====================================

# sq_operand_engine

Parametrised operand store and calculation sequencer for the stack/queue calculator. It holds DEPTH operands of DATA_W bits in a circular buffer operated as LIFO or FIFO, and accepts push, pop, clear and calc commands from debounced, single-cycle-pulsed front-panel inputs. On calc it removes two operands, presents them to the external combinational ALU, and writes the result back into the store. It sits between the button/switch front end and the ALU/seven-segment display, replacing the fixed-size stack/queue memory control.

## Interface
- DATA_W, 16, operand and result width.
- DEPTH, 16, number of entries; power of two, at least 4.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- mode  input  1  0 = stack (LIFO), 1 = queue (FIFO).
- push  input  1  one-cycle command: store push_data.
- push_data  input  DATA_W  operand to store.
- pop  input  1  one-cycle command: discard the next-out entry.
- calc  input  1  one-cycle command: pop two entries, run the ALU, store the result.
- clear  input  1  one-cycle command: empty the store.
- alu_a, alu_b  output  DATA_W  registered ALU operands.
- alu_y  input  DATA_W  combinational ALU result.
- top  output  DATA_W  next-out entry (stack top or queue head); 0 when empty.
- count  output  CNT_W  occupancy, 0..DEPTH.
- empty, full  output  1  count==0 and count==DEPTH.
- mode_q  output  1  mode currently in effect.
- busy  output  1  calc sequence in progress.
- err  output  1  one-cycle pulse when a command is rejected.

## Operation
- Reset (rst low, asynchronous): FSM goes to IDLE, pointers are cleared, count=0, alu_a=alu_b=0, mode_q=0, busy=0, err=0, empty=1, full=0, top=0. Memory contents are don't-care.
- mode_q loads from mode on any cycle where count==0 and state is IDLE. While non-empty, mode changes are ignored.
- IDLE command priority is clear > calc > pop > push. If two or more commands are asserted, only the highest executes and err pulses.
- clear: count=0 and pointers are reset. Always legal in IDLE.
- push: rejected with err when full. Stack writes at sp and sets sp+1. Queue writes at wr and sets wr+1 (mod DEPTH).
- pop: rejected with err when empty. Stack sets sp−1. Queue sets rd+1 (mod DEPTH).
- calc: rejected with err when count<2. Otherwise the FSM runs IDLE → POP_A → POP_B → EXEC → WRITE → IDLE.
  - POP_A: alu_a=top, then remove.
  - POP_B: alu_b=top, then remove.
  - EXEC: operands are stable and the result is captured from alu_y at the end of the cycle.
  - WRITE: the captured result is pushed using normal mode_q semantics. It cannot overflow, because two entries were freed.
- Any command while busy is ignored and err pulses.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH or goes below 0.

## Timing
- push, pop and clear take effect at the edge that samples them. count, empty, full and top are valid on the next cycle.
- top, empty and full are combinational from registered state, with no extra latency.
- calc sampled at edge 0 gives:
  - busy=1 from edge 0 to edge 4.
  - alu_a valid after edge 1; alu_b valid after edge 2.
  - alu_y sampled at edge 3.
  - Result visible in top/count after edge 4.
  - busy=0 and new commands accepted from edge 4 onward.
- err is high for exactly the cycle after the rejected command.
- Reset asserted mid-calc abandons the sequence. No result is written.

## Configuration
- SQ_OVERWRITE_EN defined: in queue mode, push while full overwrites the oldest entry (rd and wr both advance). count stays at DEPTH and err does not pulse. Stack mode is unchanged.
- SQ_OVERWRITE_EN undefined: push while full is rejected with err in both modes.

## Test plan
- Reset: hold rst low mid-sequence, then release → count=0, empty=1, top=0, busy=0, alu_a=alu_b=0.
- Stack: push 3, 5, 7 → top=7, count=3. Then pop → top=5.
- Queue: push 3, 5, 7 → top=3. Then calc with the ALU adding → alu_a=3, alu_b=5, top=7, then after WRITE count=2 with 8 at the tail.
- Stack calc: push 9, 4, calc with the ALU subtracting → alu_a=4, alu_b=9, result 0xFFFB (DATA_W=16) on top, count=1. calc again with count=1 → err pulse, state unchanged.
- Full/wrap: DEPTH=4 queue, push 1..4, pop twice, push 5, 6 → full=1, top=3. Push 7 gives err, or with SQ_OVERWRITE_EN gives top=4, count=4.
- Collisions: assert push+pop together → err pulse, only pop performed. Assert push during busy → err, push ignored. Change mode while count>0 → mode_q unchanged until after clear.

Source files
------------

// File: rtl/sq_operand_if.sv
// Command, ALU and status bundle for the stack/queue operand engine.
// master: front panel + ALU side; slave: sq_operand_engine.
interface sq_operand_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 5
);
  logic              mode;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic              calc;
  logic              clear;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] top;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              mode_q;
  logic              busy;
  logic              err;

  modport master (
    output mode, push, push_data, pop, calc, clear, alu_y,
    input  alu_a, alu_b, top, count, empty, full, mode_q, busy, err
  );

  modport slave (
    input  mode, push, push_data, pop, calc, clear, alu_y,
    output alu_a, alu_b, top, count, empty, full, mode_q, busy, err
  );
endinterface

// File: rtl/sq_operand_engine.sv
// Circular operand store (LIFO/FIFO) with a pop-pop-exec-write calc sequencer.
// Optional SQ_OVERWRITE_EN: queue-mode push while full overwrites the oldest entry.
module sq_operand_engine #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input logic         clk,
  input logic         rst,
  sq_operand_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [2:0] {StIdle, StPopA, StPopB, StExec, StWrite} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_q, res_d;
  logic              mode_q, mode_d, err_q, err_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              is_empty, is_full, any_cmd, multi_cmd;
  logic [PtrW-1:0]   top_idx;
  logic [DATA_W-1:0] top_val;
  logic [2:0]        n_cmd;

  // rd == wr - count holds in both modes, so mode may switch whenever empty.
  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == CNT_W'(DEPTH));
  assign top_idx   = mode_q ? rd_q : wr_q - 1'b1;
  assign top_val   = is_empty ? '0 : mem_q[top_idx];
  assign n_cmd     = {2'b0, bus.push} + {2'b0, bus.pop} + {2'b0, bus.calc} + {2'b0, bus.clear};
  assign any_cmd   = (n_cmd != 3'd0);
  assign multi_cmd = (n_cmd > 3'd1);

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    count_d   = count_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    res_d     = res_q;
    mode_d    = mode_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = bus.push_data;
    unique case (state_q)
      StIdle: begin
        if (is_empty) mode_d = bus.mode;
        err_d = multi_cmd;
        if (bus.clear) begin
          wr_d    = '0;
          rd_d    = '0;
          count_d = '0;
        end else if (bus.calc) begin
          if (count_q < CNT_W'(2)) err_d = 1'b1;
          else                     state_d = StPopA;
        end else if (bus.pop) begin
          if (is_empty) begin
            err_d = 1'b1;
          end else begin
            if (mode_q) rd_d = rd_q + 1'b1;
            else        wr_d = wr_q - 1'b1;
            count_d = count_q - 1'b1;
          end
        end else if (bus.push) begin
          if (!is_full) begin
            mem_we  = 1'b1;
            wr_d    = wr_q + 1'b1;
            count_d = count_q + 1'b1;
          end
`ifdef SQ_OVERWRITE_EN
          else if (mode_q) begin
            mem_we = 1'b1;
            wr_d   = wr_q + 1'b1;
            rd_d   = rd_q + 1'b1;
          end
`endif
          else begin
            err_d = 1'b1;
          end
        end
      end
      StPopA, StPopB: begin
        if (state_q == StPopA) alu_a_d = top_val;
        else                   alu_b_d = top_val;
        if (mode_q) rd_d = rd_q + 1'b1;
        else        wr_d = wr_q - 1'b1;
        count_d = count_q - 1'b1;
        state_d = (state_q == StPopA) ? StPopB : StExec;
      end
      StExec: begin
        res_d   = bus.alu_y;
        state_d = StWrite;
      end
      StWrite: begin
        mem_we    = 1'b1;
        mem_wdata = res_q;
        wr_d      = wr_q + 1'b1;
        count_d   = count_q + 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (state_q != StIdle && any_cmd) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      res_q   <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      res_q   <= res_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  // Storage contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_q] <= mem_wdata;
  end

  assign bus.alu_a  = alu_a_q;
  assign bus.alu_b  = alu_b_q;
  assign bus.top    = top_val;
  assign bus.count  = count_q;
  assign bus.empty  = is_empty;
  assign bus.full   = is_full;
  assign bus.mode_q = mode_q;
  assign bus.busy   = (state_q != StIdle);
  assign bus.err    = err_q;
endmodule

// File: tb/tb_sq_operand_engine.sv
// Directed + randomized bench for sq_operand_engine against a queue-based model.
module tb_sq_operand_engine;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic alu_sub = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sq_operand_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  sq_operand_engine #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External ALU: add or subtract (a - b).
  assign bus.alu_y = alu_sub ? bus.alu_a - bus.alu_b : bus.alu_a + bus.alu_b;

  // Reference model: mdl[0] is the oldest entry, mdl[$] the newest.
  logic [DW-1:0] mdl[$];
  bit            mmode = 1'b0;

  function automatic logic [DW-1:0] mtop();
    if (mdl.size() == 0) return '0;
    return mmode ? mdl[0] : mdl[mdl.size() - 1];
  endfunction

  task automatic mremove();
    if (mmode) void'(mdl.pop_front());
    else       void'(mdl.pop_back());
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".top"},   32'(bus.top),    32'(mtop()));
    chk({tag, ".count"}, 32'(bus.count),  32'(mdl.size()));
    chk({tag, ".empty"}, 32'(bus.empty),  32'(mdl.size() == 0));
    chk({tag, ".full"},  32'(bus.full),   32'(mdl.size() == DEPTH));
    chk({tag, ".modeq"}, 32'(bus.mode_q), 32'(mmode));
    chk({tag, ".busy"},  32'(bus.busy),   32'd0);
  endtask

  task automatic idle(input string tag);
    if (mdl.size() == 0) mmode = bus.mode;
    @(posedge clk); #1;
    chk({tag, ".err"}, 32'(bus.err), 32'd0);
    chk_state(tag);
  endtask

  // One command cycle; an accepted calc is followed through its whole sequence.
  task automatic cmd(input string tag, input bit p, input bit po, input bit c, input bit cl,
                     input logic [DW-1:0] d, input bit stray);
    bit            exp_err;
    bit            go_calc;
    logic [DW-1:0] a, b;
    exp_err = (int'(p) + int'(po) + int'(c) + int'(cl)) > 1;
    go_calc = 1'b0;
    if (mdl.size() == 0) mmode = bus.mode;
    if (cl) mdl.delete();
    else if (c) begin
      if (mdl.size() < 2) exp_err = 1'b1;
      else                go_calc = 1'b1;
    end else if (po) begin
      if (mdl.size() == 0) exp_err = 1'b1;
      else                 mremove();
    end else if (p) begin
      if (mdl.size() < DEPTH) mdl.push_back(d);
`ifdef SQ_OVERWRITE_EN
      else if (mmode) begin
        void'(mdl.pop_front());
        mdl.push_back(d);
      end
`endif
      else exp_err = 1'b1;
    end
    bus.push = p; bus.pop = po; bus.calc = c; bus.clear = cl; bus.push_data = d;
    @(posedge clk); #1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.calc = 1'b0; bus.clear = 1'b0;
    chk({tag, ".err"}, 32'(bus.err), 32'(exp_err));
    if (go_calc) begin
      chk({tag, ".busy0"}, 32'(bus.busy), 32'd1);
      a = mtop(); mremove();
      @(posedge clk); #1;
      chk({tag, ".alu_a"}, 32'(bus.alu_a), 32'(a));
      chk({tag, ".cnt1"}, 32'(bus.count), 32'(mdl.size()));
      b = mtop(); mremove();
      if (stray) begin bus.push = 1'b1; bus.push_data = 16'hdead; end
      @(posedge clk); #1;
      bus.push = 1'b0;
      chk({tag, ".alu_b"}, 32'(bus.alu_b), 32'(b));
      chk({tag, ".stray_err"}, 32'(bus.err), 32'(stray));
      @(posedge clk); #1;
      chk({tag, ".busy3"}, 32'(bus.busy), 32'd1);
      chk({tag, ".err3"}, 32'(bus.err), 32'd0);
      mdl.push_back(alu_sub ? a - b : a + b);
      @(posedge clk); #1;
    end
    chk_state(tag);
  endtask

  initial begin
    bus.mode = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.calc = 1'b0; bus.clear = 1'b0;
    bus.push_data = '0;
    #1;
    chk("rst.count", 32'(bus.count), 32'd0);
    chk("rst.empty", 32'(bus.empty), 32'd1);
    chk("rst.top", 32'(bus.top), 32'd0);
    chk("rst.alu_a", 32'(bus.alu_a), 32'd0);
    chk("rst.err", 32'(bus.err), 32'd0);
    @(negedge clk); rst = 1'b1;

    // Reset mid-calc abandons the sequence.
    cmd("pre1", 1, 0, 0, 0, 16'd1, 0);
    cmd("pre2", 1, 0, 0, 0, 16'd2, 0);
    bus.calc = 1'b1;
    @(posedge clk); #1;
    bus.calc = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("midrst.busy", 32'(bus.busy), 32'd0);
    chk("midrst.count", 32'(bus.count), 32'd0);
    chk("midrst.top", 32'(bus.top), 32'd0);
    chk("midrst.alu_a", 32'(bus.alu_a), 32'd0);
    chk("midrst.alu_b", 32'(bus.alu_b), 32'd0);
    chk("midrst.empty", 32'(bus.empty), 32'd1);
    mdl.delete(); mmode = 1'b0;
    @(negedge clk); rst = 1'b1;

    // Stack basics.
    cmd("stk3", 1, 0, 0, 0, 16'd3, 0);
    cmd("stk5", 1, 0, 0, 0, 16'd5, 0);
    cmd("stk7", 1, 0, 0, 0, 16'd7, 0);
    chk("stk.top7", 32'(bus.top), 32'd7);
    chk("stk.cnt3", 32'(bus.count), 32'd3);
    cmd("stkpop", 0, 1, 0, 0, 16'd0, 0);
    chk("stk.top5", 32'(bus.top), 32'd5);
    cmd("clr1", 0, 0, 0, 1, 16'd0, 0);

    // Queue with add.
    bus.mode = 1'b1;
    cmd("q3", 1, 0, 0, 0, 16'd3, 0);
    cmd("q5", 1, 0, 0, 0, 16'd5, 0);
    cmd("q7", 1, 0, 0, 0, 16'd7, 0);
    chk("q.top3", 32'(bus.top), 32'd3);
    cmd("qcalc", 0, 0, 1, 0, 16'd0, 0);
    chk("q.alu_a3", 32'(bus.alu_a), 32'd3);
    chk("q.alu_b5", 32'(bus.alu_b), 32'd5);
    chk("q.top7", 32'(bus.top), 32'd7);
    chk("q.cnt2", 32'(bus.count), 32'd2);
    cmd("qpop", 0, 1, 0, 0, 16'd0, 0);
    chk("q.tail8", 32'(bus.top), 32'd8);
    cmd("clr2", 0, 0, 0, 1, 16'd0, 0);
    idle("idle2");

    // Stack with subtract.
    bus.mode = 1'b0; alu_sub = 1'b1;
    cmd("s9", 1, 0, 0, 0, 16'd9, 0);
    cmd("s4", 1, 0, 0, 0, 16'd4, 0);
    cmd("scalc", 0, 0, 1, 0, 16'd0, 0);
    chk("s.alu_a4", 32'(bus.alu_a), 32'd4);
    chk("s.alu_b9", 32'(bus.alu_b), 32'd9);
    chk("s.topfffb", 32'(bus.top), 32'hfffb);
    cmd("scalc1", 0, 0, 1, 0, 16'd0, 0);
    chk("s.err1", 32'(bus.err), 32'd1);
    idle("s.errdrop");
    cmd("clr3", 0, 0, 0, 1, 16'd0, 0);
    idle("idle3");

    // Full and wrap in queue mode.
    bus.mode = 1'b1; alu_sub = 1'b0;
    for (int i = 1; i <= 4; i++) cmd("wfill", 1, 0, 0, 0, 16'(i), 0);
    cmd("wpop1", 0, 1, 0, 0, 16'd0, 0);
    cmd("wpop2", 0, 1, 0, 0, 16'd0, 0);
    cmd("w5", 1, 0, 0, 0, 16'd5, 0);
    cmd("w6", 1, 0, 0, 0, 16'd6, 0);
    chk("w.full", 32'(bus.full), 32'd1);
    chk("w.top3", 32'(bus.top), 32'd3);
    cmd("w7", 1, 0, 0, 0, 16'd7, 0);
`ifdef SQ_OVERWRITE_EN
    chk("w.ovw_top4", 32'(bus.top), 32'd4);
`else
    chk("w.rej_err", 32'(bus.err), 32'd1);
`endif

    // Collisions and busy rejection.
    cmd("pushpop", 1, 1, 0, 0, 16'h55, 0);
    chk("pp.err", 32'(bus.err), 32'd1);
    cmd("busypush", 0, 0, 1, 0, 16'd0, 1);
    bus.mode = 1'b0;
    cmd("modechg", 0, 1, 0, 0, 16'd0, 0);
    chk("mode.hold", 32'(bus.mode_q), 32'd1);
    cmd("clr4", 0, 0, 0, 1, 16'd0, 0);
    idle("mode.load");
    chk("mode.new", 32'(bus.mode_q), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      bus.mode = 1'($urandom);
      alu_sub  = 1'($urandom);
      if (r < 40)      cmd("rpush", 1, 0, 0, 0, 16'($urandom), 0);
      else if (r < 60) cmd("rpop", 0, 1, 0, 0, 16'd0, 0);
      else if (r < 78) cmd("rcalc", 0, 0, 1, 0, 16'd0, 1'($urandom_range(0, 3) == 0));
      else if (r < 82) cmd("rclr", 0, 0, 0, 1, 16'd0, 0);
      else if (r < 92) cmd("rmix", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                           16'($urandom), 0);
      else             idle("ridle");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
